pixel_stream_rx: RTL and testbench

PIXEL_STREAM_RX -- requirements
Module: pixel_stream_rx

---
 rtl/pixel_stream_rx.sv | 139 +++++++++++++
 tb/tb_pixel_stream_rx.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_rx.sv
// pixel_stream_rx: VSYNC/HSYNC-framed pixel-pair receiver with line/frame checks.
// Define PIXEL_STREAM_RX_CHECKSUM_EN to build the per-frame byte-sum checksum.
module pixel_stream_rx #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        VSYNC,
  input  logic        HSYNC,
  input  logic [7:0]  DATA_R0,
  input  logic [7:0]  DATA_G0,
  input  logic [7:0]  DATA_B0,
  input  logic [7:0]  DATA_R1,
  input  logic [7:0]  DATA_G1,
  input  logic [7:0]  DATA_B1,
  output logic        line_done,
  output logic        frame_done,
  output logic        len_err,
  output logic        frame_err,
  output logic [15:0] err_cnt,
  output logic [15:0] frame_cnt,
  output logic [9:0]  line_cnt,
  output logic [31:0] checksum,
  output logic        busy
);
  typedef enum logic [1:0] {ST_IDLE, ST_VSYNC, ST_GAP, ST_LINE} state_t;
  localparam logic [10:0] HALF = 11'(WIDTH / 2);
  localparam logic [9:0]  LAST = 10'(HEIGHT - 1);
  state_t      state_q, state_d;
  logic [10:0] beat_q, beat_d;
  logic [9:0]  line_cnt_q, line_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;
  logic        line_done_q, line_done_d, frame_done_q, frame_done_d;
  logic        len_err_q, len_err_d, frame_err_q, frame_err_d, busy_q, busy_d;
  logic        beat_en, ck_clr;
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    line_cnt_d   = line_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    line_done_d  = 1'b0;
    frame_done_d = 1'b0;
    len_err_d    = 1'b0;
    frame_err_d  = 1'b0;
    beat_en      = 1'b0;
    ck_clr       = 1'b0;
    case (state_q)
      ST_IDLE: state_d = VSYNC ? ST_VSYNC : ST_IDLE;
      ST_VSYNC:
        if (!VSYNC) begin
          state_d    = ST_GAP;
          line_cnt_d = '0;
          beat_d     = '0;
          ck_clr     = 1'b1;
        end
      ST_GAP:
        if (VSYNC) begin
          frame_err_d = 1'b1;
          state_d     = ST_VSYNC;
        end else if (HSYNC) begin
          state_d = ST_LINE;
          beat_d  = 11'd1;
          beat_en = 1'b1;
        end
      ST_LINE:
        // VSYNC wins over a coincident line end: the line is aborted.
        if (VSYNC) begin
          frame_err_d = 1'b1;
          state_d     = ST_VSYNC;
        end else if (HSYNC) begin
          beat_d  = (beat_q == 11'h7FF) ? beat_q : beat_q + 11'd1;
          beat_en = 1'b1;
        end else begin
          line_done_d = 1'b1;
          len_err_d   = (beat_q != HALF);
          if (line_cnt_q == LAST) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
            state_d      = ST_IDLE;
          end else begin
            line_cnt_d = line_cnt_q + 10'd1;
            beat_d     = '0;
            state_d    = ST_GAP;
          end
        end
      default: state_d = ST_IDLE;
    endcase
    err_cnt_d = ((len_err_d | frame_err_d) && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
    busy_d    = (state_d != ST_IDLE);
  end
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      line_cnt_q   <= '0;
      frame_cnt_q  <= '0;
      err_cnt_q    <= '0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      len_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      line_cnt_q   <= line_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      err_cnt_q    <= err_cnt_d;
      line_done_q  <= line_done_d;
      frame_done_q <= frame_done_d;
      len_err_q    <= len_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
`ifdef PIXEL_STREAM_RX_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d, beat_sum;
  always_comb begin
    beat_sum   = 32'(DATA_R0) + 32'(DATA_G0) + 32'(DATA_B0) + 32'(DATA_R1) + 32'(DATA_G1) + 32'(DATA_B1);
    checksum_d = ck_clr ? '0 : beat_en ? checksum_q + beat_sum : checksum_q;
  end
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) checksum_q <= '0;
    else checksum_q <= checksum_d;
  assign checksum = checksum_q;
`else
  logic unused_ck;
  assign unused_ck = ^{beat_en, ck_clr, DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1};
  assign checksum  = '0;
`endif
  assign line_done  = line_done_q;
  assign frame_done = frame_done_q;
  assign len_err    = len_err_q;
  assign frame_err  = frame_err_q;
  assign err_cnt    = err_cnt_q;
  assign frame_cnt  = frame_cnt_q;
  assign line_cnt   = line_cnt_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_pixel_stream_rx.sv
// tb_pixel_stream_rx: table-driven line/frame scenarios with an event scoreboard.
module tb_pixel_stream_rx;
  logic        HCLK = 1'b0, HRESETn = 1'b1, VSYNC = 1'b0, HSYNC = 1'b0;
  logic [7:0]  d [6];
  logic        line_done, frame_done, len_err, frame_err, busy;
  logic [15:0] err_cnt, frame_cnt;
  logic [9:0]  line_cnt;
  logic [31:0] checksum;
`ifdef PIXEL_STREAM_RX_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  pixel_stream_rx #(.WIDTH(8), .HEIGHT(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .VSYNC(VSYNC), .HSYNC(HSYNC),
    .DATA_R0(d[0]), .DATA_G0(d[1]), .DATA_B0(d[2]), .DATA_R1(d[3]), .DATA_G1(d[4]), .DATA_B1(d[5]),
    .line_done(line_done), .frame_done(frame_done), .len_err(len_err), .frame_err(frame_err),
    .err_cnt(err_cnt), .frame_cnt(frame_cnt), .line_cnt(line_cnt), .checksum(checksum), .busy(busy)
  );

  always #5 HCLK = ~HCLK;

  typedef struct { logic ld, fd, le, fe; } ev_t;
  typedef struct { bit nf; int idx, beats, abort, base, step; logic ld, le, fd, fe; int err, fc; } row_t;
  ev_t         exp_q [$];
  ev_t         ev;
  row_t        tbl [$];
  int          errors = 0, checks = 0;
  logic [31:0] exp_ck = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic add(input bit nf, input int idx, beats, abort, base, step,
                     input logic ld, le, fd, fe, input int err, fc);
    row_t r;
    r = '{nf, idx, beats, abort, base, step, ld, le, fd, fe, err, fc};
    tbl.push_back(r);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_flags"}, 32'({line_done, frame_done, len_err, frame_err, busy}), 0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
    chk({tag, "_line_cnt"}, 32'(line_cnt), 0);
    chk({tag, "_checksum"}, checksum, 0);
  endtask

  // abort: 0 none, 1 VSYNC rises on the last beat, 2 VSYNC rises on the line-end cycle
  task automatic run_row(input row_t r);
    ev_t e;
    if (r.nf) begin
      VSYNC = 1'b1;
      HSYNC = 1'b0;
      repeat (5) cyc();
      VSYNC = 1'b0;
      cyc();
      exp_ck = '0;
    end
    cyc();
    cyc();
    chk("line_cnt_at_gap", 32'(line_cnt), r.idx);
    chk("busy_at_gap", 32'(busy), 1);
    e = '{r.ld, r.fd, r.le, r.fe};
    exp_q.push_back(e);
    for (int b = 0; b < r.beats; b++) begin
      HSYNC = 1'b1;
      for (int k = 0; k < 6; k++) d[k] = 8'(r.base + r.step * (b * 6 + k));
      if (r.abort == 1 && b == r.beats - 1) VSYNC = 1'b1;
      else for (int k = 0; k < 6; k++) exp_ck += 32'(d[k]);
      cyc();
    end
    HSYNC = 1'b0;
    if (r.abort == 2) VSYNC = 1'b1;
    cyc();
    cyc();
    chk("err_cnt", 32'(err_cnt), r.err);
    chk("frame_cnt", 32'(frame_cnt), r.fc);
    if (r.abort == 0) chk("checksum", checksum, CK ? exp_ck : 32'd0);
  endtask

  always @(negedge HCLK)
    if (HRESETn && (line_done | frame_done | len_err | frame_err)) begin
      if (exp_q.size() == 0) chk("unexpected_event", 32'({line_done, frame_done, len_err, frame_err}), 0);
      else begin
        ev = exp_q.pop_front();
        chk("ev_line_done", 32'(line_done), 32'(ev.ld));
        chk("ev_frame_done", 32'(frame_done), 32'(ev.fd));
        chk("ev_len_err", 32'(len_err), 32'(ev.le));
        chk("ev_frame_err", 32'(frame_err), 32'(ev.fe));
      end
    end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    row_t r;
    for (int k = 0; k < 6; k++) d[k] = '0;
    // good frame, all bytes 1
    add(1, 0, 4, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 4, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 2, 4, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 3, 4, 0, 1, 0, 1, 0, 1, 0, 0, 1);
    // short line 1
    add(1, 0, 4, 0, 3, 1, 1, 0, 0, 0, 0, 1);
    add(0, 1, 3, 0, 3, 1, 1, 1, 0, 0, 1, 1);
    add(0, 2, 4, 0, 3, 1, 1, 0, 0, 0, 1, 1);
    add(0, 3, 4, 0, 3, 1, 1, 0, 1, 0, 1, 2);
    // long line 0
    add(1, 0, 6, 0, 7, 2, 1, 1, 0, 0, 2, 2);
    add(0, 1, 4, 0, 7, 2, 1, 0, 0, 0, 2, 2);
    add(0, 2, 4, 0, 7, 2, 1, 0, 0, 0, 2, 2);
    add(0, 3, 4, 0, 7, 2, 1, 0, 1, 0, 2, 3);
    // VSYNC mid-line 2
    add(1, 0, 4, 0, 5, 1, 1, 0, 0, 0, 2, 3);
    add(0, 1, 4, 0, 5, 1, 1, 0, 0, 0, 2, 3);
    add(0, 2, 2, 1, 5, 1, 0, 0, 0, 1, 3, 3);
    // full frame after the abort, line_cnt restarts at 0
    add(1, 0, 4, 0, 9, 3, 1, 0, 0, 0, 3, 3);
    add(0, 1, 4, 0, 9, 3, 1, 0, 0, 0, 3, 3);
    add(0, 2, 4, 0, 9, 3, 1, 0, 0, 0, 3, 3);
    add(0, 3, 4, 0, 9, 3, 1, 0, 1, 0, 3, 4);
    // VSYNC on the line-end cycle aborts the line
    add(1, 0, 4, 2, 2, 1, 0, 0, 0, 1, 4, 4);
    // back-to-back good frame
    add(1, 0, 4, 0, 11, 1, 1, 0, 0, 0, 4, 4);
    add(0, 1, 4, 0, 11, 1, 1, 0, 0, 0, 4, 4);
    add(0, 2, 4, 0, 11, 1, 1, 0, 0, 0, 4, 4);
    add(0, 3, 4, 0, 11, 1, 1, 0, 1, 0, 4, 5);

    #2 HRESETn = 1'b0;
    repeat (3) cyc();
    chk_zero("reset");
    HRESETn = 1'b1;
    cyc();
    chk_zero("post_reset");

    for (int i = 0; i < tbl.size(); i++) begin
      run_row(tbl[i]);
      if (i == 3) chk("frame_a_checksum", checksum, CK ? 32'd96 : 32'd0);
    end

    // reset in the middle of line 1
    r = tbl[0];
    r.err = 4;
    r.fc = 5;
    run_row(r);
    cyc();
    cyc();
    HSYNC = 1'b1;
    cyc();
    cyc();
    #2 HRESETn = 1'b0;
    #1 chk_zero("mid_line_reset");
    cyc();
    HRESETn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("ignored_beats_busy", 32'(busy), 0);
    end
    chk("ignored_beats_line_cnt", 32'(line_cnt), 0);
    HSYNC = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) run_row(tbl[i]);
    chk("after_reset_checksum", checksum, CK ? 32'd96 : 32'd0);

    repeat (3) cyc();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
